// File: rtl/codificador_binario_sync.sv
// Registered priority encoder: two-flop synchroniser on the raw requests, highest-index
// encode, and an output register with hold enable and a change strobe.
module codificador_binario_sync #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [N-1:0]         d,
    output logic [$clog2(N)-1:0] q,
    output logic                 valid,
    output logic                 multi,
    output logic                 changed
);
    localparam int W = $clog2(N);

    logic [N-1:0] s1_q, s2_q;
    logic [W-1:0] enc_d;
    logic         any_d, many_d;
    logic [W-1:0] q_q;
    logic         valid_q, multi_q, changed_q;

    // Stage 0/1: metastability filter, always running regardless of en
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    // Ascending scan so the highest set index is the last one written
    always_comb begin
        enc_d  = '0;
        any_d  = 1'b0;
        many_d = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (s2_q[i]) begin
                if (any_d) many_d = 1'b1;
                any_d = 1'b1;
                enc_d = W'(i);
            end
        end
    end

    // Stage 2: output register; changed compares against the value being replaced
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q       <= '0;
            valid_q   <= 1'b0;
            multi_q   <= 1'b0;
            changed_q <= 1'b0;
        end else if (en) begin
            q_q       <= enc_d;
            valid_q   <= any_d;
            multi_q   <= many_d;
            changed_q <= ({any_d, enc_d} != {valid_q, q_q});
        end else begin
            changed_q <= 1'b0;
        end
    end

    assign q       = q_q;
    assign valid   = valid_q;
    assign multi   = multi_q;
    assign changed = changed_q;
endmodule

// File: tb/tb_codificador_binario_sync.sv
// Directed bench for codificador_binario_sync (N=4): latency, priority, flags, hold and async reset.
module tb_codificador_binario_sync;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [3:0] d;
    logic [1:0] q;
    logic       valid, multi, changed;

    int checks = 0;
    int errors = 0;

    codificador_binario_sync #(.N(4)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .d(d),
        .q(q), .valid(valid), .multi(multi), .changed(changed)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; d = 4'b0000;
        #3;
        checks++;
        if ({q, valid, multi, changed} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_async got %b exp 00000", {q, valid, multi, changed});
        end
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({q, valid, multi, changed} !== 5'b00000) begin
                errors++;
                $display("FAIL reset_idle_%0d got %b exp 00000", i, {q, valid, multi, changed});
            end
        end
    endtask

    task automatic test_first_input();
        d = 4'b0001;
        step(); step();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL first_latency valid got %b exp 0", valid);
        end
        step();
        checks++;
        if ({q, valid, multi, changed} !== 5'b00101) begin
            errors++;
            $display("FAIL first_out got %b exp 00101", {q, valid, multi, changed});
        end
        step();
        checks++;
        if ({q, valid, multi, changed} !== 5'b00100) begin
            errors++;
            $display("FAIL first_pulse_end got %b exp 00100", {q, valid, multi, changed});
        end
    endtask

    task automatic test_change();
        d = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({q, valid, multi, changed} !== 5'b00100) begin
                errors++;
                $display("FAIL change_wait_%0d got %b exp 00100", i, {q, valid, multi, changed});
            end
        end
        step();
        checks++;
        if ({q, valid, multi, changed} !== 5'b10101) begin
            errors++;
            $display("FAIL change_out got %b exp 10101", {q, valid, multi, changed});
        end
        step();
        checks++;
        if ({q, valid, multi, changed} !== 5'b10100) begin
            errors++;
            $display("FAIL change_pulse_end got %b exp 10100", {q, valid, multi, changed});
        end
    endtask

    task automatic test_multi();
        d = 4'b1010;
        step(); step(); step();
        checks++;
        if ({q, valid, multi, changed} !== 5'b11111) begin
            errors++;
            $display("FAIL multi_out got %b exp 11111", {q, valid, multi, changed});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({q, valid, multi, changed} !== 5'b11110) begin
                errors++;
                $display("FAIL multi_held_%0d got %b exp 11110", i, {q, valid, multi, changed});
            end
        end
    endtask

    task automatic test_zero();
        d = 4'b0000;
        step(); step(); step();
        checks++;
        if ({q, valid, multi, changed} !== 5'b00001) begin
            errors++;
            $display("FAIL zero_out got %b exp 00001", {q, valid, multi, changed});
        end
        step();
        checks++;
        if ({q, valid, multi, changed} !== 5'b00000) begin
            errors++;
            $display("FAIL zero_pulse_end got %b exp 00000", {q, valid, multi, changed});
        end
    endtask

    task automatic test_hold();
        en = 1'b0;
        d  = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({q, valid, multi, changed} !== 5'b00000) begin
                errors++;
                $display("FAIL hold_%0d got %b exp 00000", i, {q, valid, multi, changed});
            end
        end
        en = 1'b1;
        step();
        checks++;
        if ({q, valid, multi, changed} !== 5'b01101) begin
            errors++;
            $display("FAIL hold_release got %b exp 01101", {q, valid, multi, changed});
        end
        step();
        checks++;
        if ({q, valid, multi, changed} !== 5'b01100) begin
            errors++;
            $display("FAIL hold_pulse_end got %b exp 01100", {q, valid, multi, changed});
        end
    endtask

    task automatic test_async_reset();
        d = 4'b1000;
        step(); step(); step();
        checks++;
        if ({q, valid, multi, changed} !== 5'b11101) begin
            errors++;
            $display("FAIL top_code got %b exp 11101", {q, valid, multi, changed});
        end
        step();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({q, valid, multi, changed} !== 5'b00000) begin
            errors++;
            $display("FAIL midreset got %b exp 00000", {q, valid, multi, changed});
        end
        step();
        reset_n = 1'b1;
        step(); step();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL postreset_latency valid got %b exp 0", valid);
        end
        step();
        checks++;
        if ({q, valid, multi, changed} !== 5'b11101) begin
            errors++;
            $display("FAIL postreset_out got %b exp 11101", {q, valid, multi, changed});
        end
    endtask

    initial begin
        test_reset();
        test_first_input();
        test_change();
        test_multi();
        test_zero();
        test_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
